bus_select_arbiter: RTL and testbench
=====================================

# bus_select_arbiter

Registered, parametrised successor to the datapath bus-source encoder. It takes N "source-out" request lines from the control unit and produces a binary bus-mux select plus a one-hot grant. It adds fixed-priority or round-robin arbitration, a multi-cycle bus lock, and detection and counting of illegal multi-driver requests. It sits between the control unit and the 32-bit bus multiplexer.

## Interface
Parameters:
- N_SRC, 24, number of bus sources; index = mux input number (R0..R15 = 0..15, HI 16, LO 17, Zhigh 18, Zlow 19, PC 20, MDR 21, InPort 22, C 23).
- SEL_W, $clog2(N_SRC), select width; 5 at default.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  reset; synchronous, active-high.
- req  in  N_SRC  source-out request lines; bit i = source i wants to drive the bus.
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- lock  in  1  keep the current owner while it still requests.
- cnt_clr  in  1  synchronous clear of conflict_cnt.
- select  out  SEL_W  registered binary index of the granted source.
- sel_valid  out  1  registered; 1 when select and grant are meaningful.
- grant  out  N_SRC  registered one-hot grant; all-zero when sel_valid = 0.
- conflict  out  1  registered; 1 when more than one req bit was set in the sampled cycle.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

## Operation
- Each rising edge samples req, mode and lock, then updates all outputs.
- **Idle:** req = 0 gives sel_valid = 0, grant = 0 and select = 0. select holds 0 so the mux defaults to R0.
- **Fixed priority** (mode = 0): the lowest set req index wins.
- **Round-robin** (mode = 1):
  - The search starts at (last + 1) mod N_SRC and wraps.
  - last is an internal SEL_W register, updated to the winner on every valid grant in either mode.
- **Lock:**
  - Applies when lock = 1, sel_valid = 1 and req[select] = 1.
  - Owner, select and grant are held; last is not advanced.
  - Once the owner drops req, the block re-arbitrates normally in the same cycle, even if lock is still high.
- **Conflict:**
  - conflict = (popcount(req) > 1), evaluated every cycle, including locked cycles.
  - conflict_cnt increments by 1 per conflict cycle and saturates at 2^CNT_W − 1.
  - When cnt_clr and a conflict coincide, cnt_clr wins and the counter reads 0.
- Switching mode takes effect on the next sample; last is preserved across the switch.

## Timing
- Latency is 1 cycle: req at edge k appears on select, grant and sel_valid after edge k.
- There is no combinational path from req to any output.
- Reset (clr = 1 at an edge) sets select = 0, sel_valid = 0, grant = 0, conflict = 0, conflict_cnt = 0 and last = N_SRC − 1. The first round-robin search therefore starts at index 0.
- clr overrides every other input, including during a lock; the grant drops on that edge.
- With a single requester, both modes give the same result.
- Invariants:
  - grant is always one-hot or zero.
  - grant[select] = sel_valid.

## Structure
- Package bus_sel_pkg holds:
  - source index constants SRC_R0 .. SRC_C (0..23) and SRC_NUM = 24;
  - mode constants MODE_FIXED = 0 and MODE_RR = 1.
- Sub-module rr_pick (parameters N, W):
  - Combinational.
  - Inputs: req and a start index.
  - Outputs: found flag, winning index, one-hot grant.
  - Fixed mode uses it with start = 0; round-robin uses start = last + 1 mod N.
- The top level holds the registers, lock logic, popcount > 1 detection and the counter.

## Test plan
- **Reset and idle:** assert clr for 2 cycles with req = 24'hFFFFFF → every output is 0; release clr with req = 0 → sel_valid stays 0.
- **Fixed priority:** mode = 0, req bits 20 (PC) and 5 set → next cycle select = 5, grant = 1<<5, conflict = 1, conflict_cnt = 1. Then req = bit 21 only → select = 21 (MDR), conflict = 0.
- **Round-robin fairness:** mode = 1, req bits {3, 7, 19} held 6 cycles → select sequence 3, 7, 19, 3, 7, 19; conflict_cnt = 6.
- **Lock hold and release:**
  - mode = 1, req bits {2, 9}, grant = 2, then lock = 1 for 3 cycles → select stays 2 and last is not advanced.
  - Drop req[2] with lock still high → next cycle select = 9.
- **Saturation and clear:**
  - CNT_W = 3, 10 consecutive conflict cycles → conflict_cnt = 7.
  - cnt_clr together with a conflict → conflict_cnt = 0.
- **Mid-operation reset:** clr during a locked round-robin grant of 14 → outputs zero; after release with req bits {14, 15} in mode 1 → select = 14, since the search restarts at 0.

Source files
------------

// File: rtl/bus_sel_pkg.sv
// Shared constants for the bus-source arbiter: mux input numbers and arbitration modes.
package bus_sel_pkg;

   localparam int SRC_R0     = 0;
   localparam int SRC_R1     = 1;
   localparam int SRC_R2     = 2;
   localparam int SRC_R3     = 3;
   localparam int SRC_R4     = 4;
   localparam int SRC_R5     = 5;
   localparam int SRC_R6     = 6;
   localparam int SRC_R7     = 7;
   localparam int SRC_R8     = 8;
   localparam int SRC_R9     = 9;
   localparam int SRC_R10    = 10;
   localparam int SRC_R11    = 11;
   localparam int SRC_R12    = 12;
   localparam int SRC_R13    = 13;
   localparam int SRC_R14    = 14;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHIGH  = 18;
   localparam int SRC_ZLOW   = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_C      = 23;
   localparam int SRC_NUM    = 24;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular search: first set req bit at or after start, wrapping at N.
module rr_pick #(
   parameter int N = 24,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] index,
   output logic [N-1:0] grant
);

   logic [W-1:0] pos [N];
   logic [N-1:0] hit;

   // pos[gi] is the source examined at search offset gi; start is always < N
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_offset
         logic [W:0] sum;
         assign sum     = {1'b0, start} + (W+1)'(gi);
         assign pos[gi] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
         assign hit[gi] = req[pos[gi]];
      end
   endgenerate

   always_comb begin
      found = 1'b0;
      index = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (hit[k]) begin
            found = 1'b1;
            index = pos[k];
         end
      end
      grant = found ? (N'(1) << index) : '0;
   end

endmodule

// File: rtl/bus_select_arbiter.sv
// Registered bus-source arbiter: fixed/round-robin grant, owner lock, multi-driver detection.
module bus_select_arbiter
   import bus_sel_pkg::*;
#(
   parameter int N_SRC = SRC_NUM,
   parameter int SEL_W = $clog2(N_SRC),
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [N_SRC-1:0] req,
   input  logic             mode,
   input  logic             lock,
   input  logic             cnt_clr,
   output logic [SEL_W-1:0] select,
   output logic             sel_valid,
   output logic [N_SRC-1:0] grant,
   output logic             conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_SRC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [SEL_W-1:0] select_reg;
   logic             sel_valid_reg;
   logic [N_SRC-1:0] grant_reg;
   logic             conflict_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [SEL_W-1:0] last_reg;

   logic [SEL_W-1:0] start_next;
   logic             found_next;
   logic [SEL_W-1:0] index_next;
   logic [N_SRC-1:0] grant_next;
   logic             hold_next;
   logic             conflict_next;

   assign start_next = (mode == MODE_RR) ?
                       ((last_reg == LAST_IDX) ? '0 : last_reg + SEL_W'(1)) : '0;

   rr_pick #(
      .N (N_SRC),
      .W (SEL_W)
   ) u_pick (
      .req   (req),
      .start (start_next),
      .found (found_next),
      .index (index_next),
      .grant (grant_next)
   );

   // Clearing the lowest set bit leaves something only if two or more bits were set
   assign conflict_next = |(req & (req - N_SRC'(1)));
   assign hold_next     = lock && sel_valid_reg && req[select_reg];

   always_ff @(posedge clk) begin
      if (clr) begin
         select_reg    <= '0;
         sel_valid_reg <= 1'b0;
         grant_reg     <= '0;
         conflict_reg  <= 1'b0;
         cnt_reg       <= '0;
         last_reg      <= LAST_IDX;
      end else begin
         conflict_reg <= conflict_next;
         if (cnt_clr)
            cnt_reg <= '0;
         else if (conflict_next && cnt_reg != CNT_MAX)
            cnt_reg <= cnt_reg + CNT_W'(1);

         if (!hold_next) begin
            if (found_next) begin
               select_reg    <= index_next;
               sel_valid_reg <= 1'b1;
               grant_reg     <= grant_next;
               last_reg      <= index_next;
            end else begin
               select_reg    <= '0;
               sel_valid_reg <= 1'b0;
               grant_reg     <= '0;
            end
         end
      end
   end

   assign select       = select_reg;
   assign sel_valid    = sel_valid_reg;
   assign grant        = grant_reg;
   assign conflict     = conflict_reg;
   assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Directed vector table plus hand sequences for saturation and mid-lock reset.
module tb_bus_select_arbiter;
   import bus_sel_pkg::*;

   localparam int N     = 24;
   localparam int SW    = 5;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          clr;
   logic [N-1:0]  req;
   logic          mode;
   logic          lock;
   logic          cnt_clr;
   logic [SW-1:0] select;
   logic          sel_valid;
   logic [N-1:0]  grant;
   logic          conflict;
   logic [CW-1:0] conflict_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bus_select_arbiter #(
      .N_SRC (N),
      .SEL_W (SW),
      .CNT_W (CW)
   ) dut (
      .clk          (clk),
      .clr          (clr),
      .req          (req),
      .mode         (mode),
      .lock         (lock),
      .cnt_clr      (cnt_clr),
      .select       (select),
      .sel_valid    (sel_valid),
      .grant        (grant),
      .conflict     (conflict),
      .conflict_cnt (conflict_cnt)
   );

   typedef struct {
      string        name;
      logic         clr;
      logic [N-1:0] req;
      logic         mode;
      logic         lock;
      logic         cnt_clr;
      int           sel;
      logic         valid;
      logic         conf;
      int           cnt;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   function automatic vec_t mk(string name, logic c, logic [N-1:0] r, logic m, logic l,
                               logic cc, int sel, logic valid, logic conf, int cnt);
      vec_t v;
      v.name = name; v.clr = c; v.req = r; v.mode = m; v.lock = l; v.cnt_clr = cc;
      v.sel = sel; v.valid = valid; v.conf = conf; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [N-1:0] bits3(int a, int b, int c);
      logic [N-1:0] r;
      r = '0;
      if (a >= 0) r[a] = 1'b1;
      if (b >= 0) r[b] = 1'b1;
      if (c >= 0) r[c] = 1'b1;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(logic c, logic [N-1:0] r, logic m, logic l, logic cc);
      clr = c; req = r; mode = m; lock = l; cnt_clr = cc;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(string name, int sel, logic valid, logic conf, int cnt);
      logic [N-1:0] g;
      g = valid ? (N'(1) << sel) : '0;
      chk({name, ".select"}, 32'(select), 32'(sel));
      chk({name, ".sel_valid"}, 32'(sel_valid), 32'(valid));
      chk({name, ".grant"}, 32'(grant), 32'(g));
      chk({name, ".conflict"}, 32'(conflict), 32'(conf));
      chk({name, ".conflict_cnt"}, 32'(conflict_cnt), 32'(cnt));
      $display("vec %-10s req=%06h -> select=%0d valid=%0b grant=%06h conflict=%0b cnt=%0d",
               name, req, select, sel_valid, grant, conflict, conflict_cnt);
   endtask

   initial begin
      clr = 1'b1; req = '0; mode = MODE_FIXED; lock = 1'b0; cnt_clr = 1'b0;

      vecs[0]  = mk("rst0",  1, 24'hFFFFFF, 0, 0, 0,  0, 0, 0, 0);
      vecs[1]  = mk("rst1",  1, 24'hFFFFFF, 0, 0, 0,  0, 0, 0, 0);
      vecs[2]  = mk("idle",  0, '0,         0, 0, 0,  0, 0, 0, 0);
      vecs[3]  = mk("fix20_5", 0, bits3(SRC_PC, 5, -1), 0, 0, 0, 5, 1, 1, 1);
      vecs[4]  = mk("fix_mdr", 0, bits3(SRC_MDR, -1, -1), 0, 0, 0, 21, 1, 0, 1);
      vecs[5]  = mk("cclr",  0, '0,         1, 0, 1,  0, 0, 0, 0);
      vecs[6]  = mk("rr1",   0, bits3(3, 7, 19), 1, 0, 0,  3, 1, 1, 1);
      vecs[7]  = mk("rr2",   0, bits3(3, 7, 19), 1, 0, 0,  7, 1, 1, 2);
      vecs[8]  = mk("rr3",   0, bits3(3, 7, 19), 1, 0, 0, 19, 1, 1, 3);
      vecs[9]  = mk("rr4",   0, bits3(3, 7, 19), 1, 0, 0,  3, 1, 1, 4);
      vecs[10] = mk("rr5",   0, bits3(3, 7, 19), 1, 0, 0,  7, 1, 1, 5);
      vecs[11] = mk("rr6",   0, bits3(3, 7, 19), 1, 0, 0, 19, 1, 1, 6);
      vecs[12] = mk("lk_arb", 0, bits3(2, 9, -1), 1, 0, 1,  2, 1, 1, 0);
      vecs[13] = mk("lk1",   0, bits3(2, 9, -1), 1, 1, 0,  2, 1, 1, 1);
      vecs[14] = mk("lk2",   0, bits3(2, 9, -1), 1, 1, 0,  2, 1, 1, 2);
      vecs[15] = mk("lk3",   0, bits3(2, 9, -1), 1, 1, 0,  2, 1, 1, 3);
      vecs[16] = mk("lk_rel", 0, bits3(9, -1, -1), 1, 1, 0,  9, 1, 0, 3);

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].clr, vecs[i].req, vecs[i].mode, vecs[i].lock, vecs[i].cnt_clr);
         check_all(vecs[i].name, vecs[i].sel, vecs[i].valid, vecs[i].conf, vecs[i].cnt);
      end

      // last = 9 after the release, so {2,9} now searches from 10 and wraps to 2
      step(0, bits3(2, 9, -1), 1, 0, 0);
      check_all("rr_wrap", 2, 1, 1, 4);

      // Saturation: cnt_clr beats a coincident conflict, then 10 conflicts clamp at 7
      step(0, bits3(0, 1, -1), 0, 0, 1);
      check_all("sat_clr", 0, 1, 1, 0);
      for (int k = 1; k <= 10; k++) begin
         step(0, bits3(0, 1, -1), 0, 0, 0);
         check_all($sformatf("sat%0d", k), 0, 1, 1, (k > 7) ? 7 : k);
      end
      step(0, bits3(0, 1, -1), 0, 0, 1);
      check_all("sat_cclr", 0, 1, 1, 0);

      // Mid-operation reset during a locked grant of 14
      step(0, bits3(14, -1, -1), 1, 0, 0);
      check_all("m_own14", 14, 1, 0, 0);
      step(0, bits3(14, 15, -1), 1, 1, 0);
      check_all("m_lock", 14, 1, 1, 1);
      step(1, bits3(14, 15, -1), 1, 1, 0);
      check_all("m_clr", 0, 0, 0, 0);
      step(0, bits3(14, 15, -1), 1, 0, 0);
      check_all("m_after", 14, 1, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
